piezo_player_arbiter: RTL and testbench
=======================================

Name: piezo_player_arbiter

Overview:
- Shares the single Morse piezo player (bitstream + DitTime/DahTime/DitGap timing) between NUM_REQ requesters, e.g. settings-UI demo, encoder echo and decoder feedback.
- Arbitrates start requests and snapshots the winner's bitstream and timing.
- Sequences start/done with the player, inserts a guard gap between playbacks, and gates the piezo output.
- Sits between the UI/encoder blocks and the one player instance.

Parameters:
- NUM_REQ, 3: number of requesters; index 0 has the highest priority.
- GAP_CYCLES, 2_500_000: silent guard interval after each playback, in clk cycles.
- MAX_PLAY_CYCLES, 500_000_000: watchdog limit for one playback, in clk cycles.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req  in  NUM_REQ  level request per requester
- req_bitstream  in  NUM_REQ*256  packed bitstreams; requester i occupies [i*256 +: 256]
- req_bit_length  in  NUM_REQ*9  packed bit lengths
- req_dit_time  in  NUM_REQ*32  packed dit times
- req_dah_time  in  NUM_REQ*32  packed dah times
- req_dit_gap  in  NUM_REQ*32  packed dit gaps
- gnt  out  NUM_REQ  one-hot grant, held for the whole playback
- done  out  NUM_REQ  1-cycle completion pulse to the granted requester
- err  out  1  1-cycle pulse on watchdog abort
- ply_start  out  1  start pulse to the player
- ply_abort  out  1  1-cycle abort pulse to the player
- ply_bitstream  out  256  snapshot to the player
- ply_bit_length  out  9  snapshot to the player
- ply_dit_time  out  32  snapshot to the player
- ply_dah_time  out  32  snapshot to the player
- ply_dit_gap  out  32  snapshot to the player
- ply_busy  in  1  player busy
- ply_done  in  1  player done pulse
- piezo_in  in  1  raw player tone
- piezo_out  out  1  gated tone

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE.
  - gnt, done, err, ply_start, ply_abort = 0; piezo_out = 0.
  - ply_* snapshot registers = 0; counters = 0.
- States: IDLE, LAUNCH, PLAY, GAP.
- IDLE:
  - If any req bit is set, select the lowest set index i.
  - Next clock: gnt = one-hot(i); ply_* registers load requester i's fields; go to LAUNCH.
- LAUNCH:
  - ply_start = 1 for exactly one cycle (the cycle after the snapshot).
  - Watchdog counter cleared; go to PLAY.
- PLAY:
  - Watchdog counter increments each cycle.
  - On ply_done = 1: done[i] pulses for 1 cycle; gnt clears the same cycle; counter cleared; go to GAP.
  - If the counter reaches MAX_PLAY_CYCLES-1 without ply_done:
    - ply_abort and err pulse for 1 cycle.
    - done[i] also pulses.
    - gnt clears; go to GAP.
  - If ply_done and the watchdog limit coincide, ply_done wins: no err, no abort.
- GAP:
  - Counter counts 0..GAP_CYCLES-1, then return to IDLE.
  - req is ignored during GAP.
  - GAP_CYCLES = 0 means GAP lasts 1 cycle.
- Request handshake:
  - req is level-sensitive. A requester keeps req high until it sees done, then drops it.
  - req still high when IDLE is re-entered is a new request and causes a replay.
  - Dropping req during LAUNCH/PLAY has no effect; playback completes (non-preemptive base).
- Snapshot: the ply_* outputs are stable from LAUNCH until the next grant. Requesters may change their inputs freely after the grant.
- Latency: req rise in IDLE → gnt at +1 clock → ply_start at +2 clocks.
- Gating: piezo_out = piezo_in when state is LAUNCH or PLAY; otherwise 0.
- ply_busy is informational only; sequencing uses ply_done.
- Simultaneous events: multiple req in IDLE → lowest index wins; others wait, no starvation guarantee.
- Mid-operation reset → immediate return to reset values; the player is reset by the same rst_n.

Optional Feature:
- Macro PIEZO_ARB_PREEMPT_EN.
- Defined: in PLAY, a req from an index lower than the granted one triggers, in the same cycle:
  - ply_abort pulses for 1 cycle and done[granted] pulses (err stays 0).
  - gnt clears and the state moves to GAP.
  - The higher-priority requester is granted after GAP.
- Undefined: no preemption. ply_abort is driven only by the watchdog.

Test Plan:
- Single request: req=3'b010, bit_length=72, dit=500_000; ply_done at cycle 1000 → gnt=010 at +1, ply_start at +2 with exact snapshot values, done[1] pulse, piezo_out silent during GAP.
- Contention: req=3'b110 in IDLE → gnt=010 first; after done and GAP_CYCLES, gnt=100 follows.
- Snapshot: change req_dit_time[0] during PLAY → ply_dit_time unchanged until the next grant.
- Watchdog: MAX_PLAY_CYCLES=100, no ply_done → ply_abort, err and done[i] pulse at cycle 100 after start; ply_done arriving on cycle 100 instead → no err.
- Reset mid-PLAY: assert rst_n=0 → all outputs 0 asynchronously; req still high after release → fresh grant at +1.
- PIEZO_ARB_PREEMPT_EN defined, playing requester 2, req[0] rises → ply_abort and done[2] pulse the same cycle, err=0, gnt=001 after GAP.

Source files
------------

// File: rtl/piezo_player_arbiter.sv
// Priority arbiter that shares one Morse piezo player among NUM_REQ requesters (index 0 highest).
// Optional feature macro: PIEZO_ARB_PREEMPT_EN lets a higher-priority request abort a playback.
module piezo_player_arbiter #(
    parameter int NUM_REQ         = 3,
    parameter int GAP_CYCLES      = 2_500_000,
    parameter int MAX_PLAY_CYCLES = 500_000_000
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NUM_REQ-1:0]     req_i,
    input  logic [NUM_REQ*256-1:0] req_bitstream_i,
    input  logic [NUM_REQ*9-1:0]   req_bit_length_i,
    input  logic [NUM_REQ*32-1:0]  req_dit_time_i,
    input  logic [NUM_REQ*32-1:0]  req_dah_time_i,
    input  logic [NUM_REQ*32-1:0]  req_dit_gap_i,
    output logic [NUM_REQ-1:0]     gnt_o,
    output logic [NUM_REQ-1:0]     done_o,
    output logic                   err_o,
    output logic                   ply_start_o,
    output logic                   ply_abort_o,
    output logic [255:0]           ply_bitstream_o,
    output logic [8:0]             ply_bit_length_o,
    output logic [31:0]            ply_dit_time_o,
    output logic [31:0]            ply_dah_time_o,
    output logic [31:0]            ply_dit_gap_o,
    input  logic                   ply_busy_i,
    input  logic                   ply_done_i,
    input  logic                   piezo_in_i,
    output logic                   piezo_out_o
);

    localparam logic [NUM_REQ-1:0] ONE_REQ  = NUM_REQ'(1);
    localparam logic [31:0]        GAP_LAST = (GAP_CYCLES > 0) ? 32'(GAP_CYCLES - 1) : 32'd0;
    localparam logic [31:0]        WD_LAST  = (MAX_PLAY_CYCLES > 0) ? 32'(MAX_PLAY_CYCLES - 1) : 32'd0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        PLAY   = 2'd2,
        GAP    = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        cnt_q, cnt_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               err_q, err_d;
    logic               start_q, start_d;
    logic               abort_q, abort_d;
    logic [255:0]       bitstream_q, bitstream_d;
    logic [8:0]         bitLength_q, bitLength_d;
    logic [31:0]        ditTime_q, ditTime_d;
    logic [31:0]        dahTime_q, dahTime_d;
    logic [31:0]        ditGap_q, ditGap_d;

    logic [NUM_REQ-1:0] winOneHot;
    logic               unusedPlyBusy;

    // Isolate the lowest set request bit: that requester has the highest priority.
    assign winOneHot     = req_i & (~req_i + ONE_REQ);
    assign unusedPlyBusy = ply_busy_i;

`ifdef PIEZO_ARB_PREEMPT_EN
    logic preemptReq;
    // gnt_q is one-hot in PLAY, so gnt_q - 1 masks exactly the higher-priority indices.
    assign preemptReq = |(req_i & (gnt_q - ONE_REQ));
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        done_d      = '0;
        err_d       = 1'b0;
        start_d     = 1'b0;
        abort_d     = 1'b0;
        bitstream_d = bitstream_q;
        bitLength_d = bitLength_q;
        ditTime_d   = ditTime_q;
        dahTime_d   = dahTime_q;
        ditGap_d    = ditGap_q;

        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    gnt_d   = winOneHot;
                    state_d = LAUNCH;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (winOneHot[i]) begin
                            bitstream_d = req_bitstream_i[i*256 +: 256];
                            bitLength_d = req_bit_length_i[i*9 +: 9];
                            ditTime_d   = req_dit_time_i[i*32 +: 32];
                            dahTime_d   = req_dah_time_i[i*32 +: 32];
                            ditGap_d    = req_dit_gap_i[i*32 +: 32];
                        end
                    end
                end
            end

            LAUNCH: begin
                start_d = 1'b1;
                cnt_d   = '0;
                state_d = PLAY;
            end

            PLAY: begin
                cnt_d = cnt_q + 32'd1;
                // A real completion always beats a coincident watchdog expiry.
                if (ply_done_i) begin
                    done_d  = gnt_q;
                    gnt_d   = '0;
                    cnt_d   = '0;
                    state_d = GAP;
                end
`ifdef PIEZO_ARB_PREEMPT_EN
                else if (preemptReq) begin
                    abort_d = 1'b1;
                    done_d  = gnt_q;
                    gnt_d   = '0;
                    cnt_d   = '0;
                    state_d = GAP;
                end
`endif
                else if (cnt_q >= WD_LAST) begin
                    abort_d = 1'b1;
                    err_d   = 1'b1;
                    done_d  = gnt_q;
                    gnt_d   = '0;
                    cnt_d   = '0;
                    state_d = GAP;
                end
            end

            GAP: begin
                if (cnt_q >= GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            default: begin
                cnt_d   = '0;
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            gnt_q       <= '0;
            done_q      <= '0;
            err_q       <= 1'b0;
            start_q     <= 1'b0;
            abort_q     <= 1'b0;
            bitstream_q <= '0;
            bitLength_q <= '0;
            ditTime_q   <= '0;
            dahTime_q   <= '0;
            ditGap_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
            start_q     <= start_d;
            abort_q     <= abort_d;
            bitstream_q <= bitstream_d;
            bitLength_q <= bitLength_d;
            ditTime_q   <= ditTime_d;
            dahTime_q   <= dahTime_d;
            ditGap_q    <= ditGap_d;
        end
    end

    assign gnt_o            = gnt_q;
    assign done_o           = done_q;
    assign err_o            = err_q;
    assign ply_start_o      = start_q;
    assign ply_abort_o      = abort_q;
    assign ply_bitstream_o  = bitstream_q;
    assign ply_bit_length_o = bitLength_q;
    assign ply_dit_time_o   = ditTime_q;
    assign ply_dah_time_o   = dahTime_q;
    assign ply_dit_gap_o    = ditGap_q;
    assign piezo_out_o      = piezo_in_i & ((state_q == LAUNCH) || (state_q == PLAY));

endmodule

// File: tb/tb_piezo_player_arbiter.sv
// Randomized self-checking bench for piezo_player_arbiter with a transaction-level priority model.
// Build with PIEZO_ARB_PREEMPT_EN defined to exercise the preemption path.
module tb_piezo_player_arbiter;

    localparam int NREQ = 3;
    localparam int GAP  = 5;
    localparam int MAXP = 100;

    logic              clk = 1'b0;
    logic              rstN;
    logic [NREQ-1:0]   reqVec;
    logic [255:0]      fBs  [NREQ];
    logic [8:0]        fLen [NREQ];
    logic [31:0]       fDit [NREQ];
    logic [31:0]       fDah [NREQ];
    logic [31:0]       fGap [NREQ];
    logic [NREQ*256-1:0] reqBitstream;
    logic [NREQ*9-1:0]   reqBitLength;
    logic [NREQ*32-1:0]  reqDitTime;
    logic [NREQ*32-1:0]  reqDahTime;
    logic [NREQ*32-1:0]  reqDitGap;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic              err;
    logic              plyStart;
    logic              plyAbort;
    logic [255:0]      plyBitstream;
    logic [8:0]        plyBitLength;
    logic [31:0]       plyDitTime;
    logic [31:0]       plyDahTime;
    logic [31:0]       plyDitGap;
    logic              plyBusy;
    logic              plyDone;
    logic              piezoIn;
    logic              piezoOut;

    logic [255:0]      expBs;
    logic [8:0]        expLen;
    logic [31:0]       expDit;
    logic [31:0]       expDah;
    logic [31:0]       expGap;

    int checks = 0;
    int errors = 0;

    assign reqBitstream = {fBs[2], fBs[1], fBs[0]};
    assign reqBitLength = {fLen[2], fLen[1], fLen[0]};
    assign reqDitTime   = {fDit[2], fDit[1], fDit[0]};
    assign reqDahTime   = {fDah[2], fDah[1], fDah[0]};
    assign reqDitGap    = {fGap[2], fGap[1], fGap[0]};

    piezo_player_arbiter #(
        .NUM_REQ(NREQ),
        .GAP_CYCLES(GAP),
        .MAX_PLAY_CYCLES(MAXP)
    ) dut (
        .clk_i(clk),
        .rst_ni(rstN),
        .req_i(reqVec),
        .req_bitstream_i(reqBitstream),
        .req_bit_length_i(reqBitLength),
        .req_dit_time_i(reqDitTime),
        .req_dah_time_i(reqDahTime),
        .req_dit_gap_i(reqDitGap),
        .gnt_o(gnt),
        .done_o(done),
        .err_o(err),
        .ply_start_o(plyStart),
        .ply_abort_o(plyAbort),
        .ply_bitstream_o(plyBitstream),
        .ply_bit_length_o(plyBitLength),
        .ply_dit_time_o(plyDitTime),
        .ply_dah_time_o(plyDahTime),
        .ply_dit_gap_o(plyDitGap),
        .ply_busy_i(plyBusy),
        .ply_done_i(plyDone),
        .piezo_in_i(piezoIn),
        .piezo_out_o(piezoOut)
    );

    always #5 clk = ~clk;

    // Model rule: the lowest set request index wins.
    function automatic int lowestIdx(input logic [NREQ-1:0] r);
        for (int i = 0; i < NREQ; i++) begin
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic randomizeFields();
        for (int i = 0; i < NREQ; i++) begin
            for (int j = 0; j < 8; j++) fBs[i][j*32 +: 32] = $urandom();
            fLen[i] = 9'($urandom_range(1, 511));
            fDit[i] = $urandom();
            fDah[i] = $urandom();
            fGap[i] = $urandom();
        end
    endtask

    task automatic saveExpected(input int w);
        expBs  = fBs[w];
        expLen = fLen[w];
        expDit = fDit[w];
        expDah = fDah[w];
        expGap = fGap[w];
    endtask

    // One full transaction from IDLE: grant, start, play (mode 0 = ply_done after playLen cycles,
    // 1 = watchdog expiry, 2 = ply_done on the watchdog cycle), done and guard gap.
    task automatic playOne(input int playLen, input int mode, input bit dropEarly, input bit keepAfter);
        int w;
        int preTicks;
        logic [NREQ-1:0] expOh;
        w = lowestIdx(reqVec);
        if (w < 0) w = 0;
        expOh = '0;
        expOh[w] = 1'b1;
        tick();
        checks++;
        if (gnt !== expOh) begin errors++; $display("[TB] FAIL grant: got %b expected %b", gnt, expOh); end
        checks++;
        if (plyStart !== 1'b0) begin errors++; $display("[TB] FAIL start_early: got %b expected 0", plyStart); end
        saveExpected(w);
        checks++;
        if ({plyBitstream, plyBitLength, plyDitTime, plyDahTime, plyDitGap} !== {expBs, expLen, expDit, expDah, expGap}) begin
            errors++;
            $display("[TB] FAIL snapshot_load: got %h expected %h", {plyBitLength, plyDitTime, plyDahTime, plyDitGap}, {expLen, expDit, expDah, expGap});
        end
        piezoIn = 1'b1;
        #1;
        checks++;
        if (piezoOut !== 1'b1) begin errors++; $display("[TB] FAIL gate_launch: got %b expected 1", piezoOut); end
        if (dropEarly) reqVec[w] = 1'b0;
        tick();
        checks++;
        if (plyStart !== 1'b1 || gnt !== expOh) begin
            errors++;
            $display("[TB] FAIL start_pulse: got start=%b gnt=%b expected start=1 gnt=%b", plyStart, gnt, expOh);
        end
        preTicks = (mode == 0) ? playLen : MAXP - 1;
        for (int k = 0; k < preTicks; k++) begin
            randomizeFields();
            piezoIn = 1'($urandom());
            plyBusy = 1'b1;
            tick();
            checks++;
            if ({plyStart, plyAbort, err, done} !== 6'b0 || gnt !== expOh) begin
                errors++;
                $display("[TB] FAIL play_quiet: got start=%b abort=%b err=%b done=%b gnt=%b expected 0/0/0/000/%b",
                         plyStart, plyAbort, err, done, gnt, expOh);
            end
            checks++;
            if ({plyBitstream, plyBitLength, plyDitTime, plyDahTime, plyDitGap} !== {expBs, expLen, expDit, expDah, expGap}) begin
                errors++;
                $display("[TB] FAIL snapshot_hold: got %h expected %h", {plyBitLength, plyDitTime, plyDahTime, plyDitGap}, {expLen, expDit, expDah, expGap});
            end
            checks++;
            if (piezoOut !== piezoIn) begin errors++; $display("[TB] FAIL gate_play: got %b expected %b", piezoOut, piezoIn); end
        end
        plyDone = (mode != 1);
        tick();
        plyDone = 1'b0;
        plyBusy = 1'b0;
        checks++;
        if (done !== expOh || gnt !== 3'b000) begin
            errors++;
            $display("[TB] FAIL finish_done: got done=%b gnt=%b expected done=%b gnt=000", done, gnt, expOh);
        end
        checks++;
        if (err !== (mode == 1) || plyAbort !== (mode == 1)) begin
            errors++;
            $display("[TB] FAIL finish_abort: got err=%b abort=%b expected %0d", err, plyAbort, (mode == 1));
        end
        piezoIn = 1'b1;
        #1;
        checks++;
        if (piezoOut !== 1'b0) begin errors++; $display("[TB] FAIL gate_gap: got %b expected 0", piezoOut); end
        if (!keepAfter) reqVec[w] = 1'b0;
        for (int g = 1; g <= GAP; g++) begin
            randomizeFields();
            tick();
            checks++;
            if ({gnt, done, err, plyAbort, plyStart} !== 9'b0) begin
                errors++;
                $display("[TB] FAIL gap_quiet: got gnt=%b done=%b err=%b abort=%b start=%b at gap cycle %0d expected all 0",
                         gnt, done, err, plyAbort, plyStart, g);
            end
            checks++;
            if ({plyBitstream, plyBitLength, plyDitTime, plyDahTime, plyDitGap} !== {expBs, expLen, expDit, expDah, expGap}) begin
                errors++;
                $display("[TB] FAIL snapshot_gap: got %h expected %h", {plyBitLength, plyDitTime, plyDahTime, plyDitGap}, {expLen, expDit, expDah, expGap});
            end
        end
    endtask

    task automatic test_reset();
        rstN    = 1'b0;
        reqVec  = 3'b111;
        piezoIn = 1'b1;
        repeat (2) tick();
        checks++;
        if ({gnt, done, err, plyStart, plyAbort, piezoOut} !== 10'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got gnt=%b done=%b err=%b start=%b abort=%b piezo=%b expected all 0",
                     gnt, done, err, plyStart, plyAbort, piezoOut);
        end
        checks++;
        if ({plyBitstream, plyBitLength, plyDitTime, plyDahTime, plyDitGap} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_snapshot: got %h expected 0", {plyBitLength, plyDitTime, plyDahTime, plyDitGap});
        end
        reqVec = '0;
        rstN   = 1'b1;
        tick();
        checks++;
        if (gnt !== 3'b000) begin errors++; $display("[TB] FAIL idle_no_req: got %b expected 000", gnt); end
    endtask

    task automatic test_single();
        randomizeFields();
        fLen[1] = 9'd72;
        fDit[1] = 32'd500_000;
        reqVec  = 3'b010;
        playOne(40, 0, 1'b0, 1'b0);
    endtask

    task automatic test_contention();
        randomizeFields();
        reqVec = 3'b110;
        playOne($urandom_range(0, 30), 0, 1'b0, 1'b0);
        playOne($urandom_range(0, 30), 0, 1'b0, 1'b0);
    endtask

    task automatic test_snapshot();
        randomizeFields();
        reqVec = 3'b001;
        playOne(70, 0, 1'b1, 1'b0);
    endtask

    task automatic test_watchdog();
        randomizeFields();
        reqVec = 3'b100;
        playOne(0, 1, 1'b0, 1'b0);
        randomizeFields();
        reqVec = 3'b010;
        playOne(0, 2, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        randomizeFields();
        reqVec = 3'b001;
        playOne($urandom_range(0, 20), 0, 1'b0, 1'b1);
        playOne($urandom_range(0, 20), 0, 1'b0, 1'b0);
    endtask

    task automatic test_priority_raise();
        randomizeFields();
        reqVec = 3'b100;
        tick();
        checks++;
        if (gnt !== 3'b100) begin errors++; $display("[TB] FAIL raise_grant: got %b expected 100", gnt); end
        repeat (4) tick();
        reqVec[0] = 1'b1;
        tick();
`ifdef PIEZO_ARB_PREEMPT_EN
        checks++;
        if (plyAbort !== 1'b1 || done !== 3'b100 || err !== 1'b0 || gnt !== 3'b000) begin
            errors++;
            $display("[TB] FAIL preempt: got abort=%b done=%b err=%b gnt=%b expected 1/100/0/000", plyAbort, done, err, gnt);
        end
`else
        checks++;
        if (plyAbort !== 1'b0 || done !== 3'b000 || gnt !== 3'b100) begin
            errors++;
            $display("[TB] FAIL no_preempt: got abort=%b done=%b gnt=%b expected 0/000/100", plyAbort, done, gnt);
        end
        plyDone = 1'b1;
        tick();
        plyDone = 1'b0;
        checks++;
        if (done !== 3'b100 || gnt !== 3'b000 || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL raise_done: got done=%b gnt=%b err=%b expected 100/000/0", done, gnt, err);
        end
`endif
        reqVec[2] = 1'b0;
        for (int g = 1; g <= GAP; g++) begin
            tick();
            checks++;
            if ({gnt, done, err, plyAbort} !== 8'b0) begin
                errors++;
                $display("[TB] FAIL raise_gap: got gnt=%b done=%b err=%b abort=%b expected all 0", gnt, done, err, plyAbort);
            end
        end
        playOne($urandom_range(0, 20), 0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_play();
        int w;
        logic [NREQ-1:0] expOh;
        randomizeFields();
        reqVec = 3'($urandom_range(1, 7));
        w = lowestIdx(reqVec);
        expOh = '0;
        expOh[w] = 1'b1;
        tick();
        checks++;
        if (gnt !== expOh) begin errors++; $display("[TB] FAIL mid_grant: got %b expected %b", gnt, expOh); end
        repeat (4) tick();
        rstN    = 1'b0;
        piezoIn = 1'b1;
        #1;
        checks++;
        if ({gnt, done, err, plyStart, plyAbort, piezoOut} !== 10'b0) begin
            errors++;
            $display("[TB] FAIL reset_async: got gnt=%b done=%b err=%b start=%b abort=%b piezo=%b expected all 0",
                     gnt, done, err, plyStart, plyAbort, piezoOut);
        end
        checks++;
        if ({plyBitstream, plyBitLength, plyDitTime, plyDahTime, plyDitGap} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_async_snap: got %h expected 0", {plyBitLength, plyDitTime, plyDahTime, plyDitGap});
        end
        #2;
        rstN = 1'b1;
        randomizeFields();
        saveExpected(w);
        tick();
        checks++;
        if (gnt !== expOh) begin errors++; $display("[TB] FAIL reset_regrant: got %b expected %b", gnt, expOh); end
        checks++;
        if ({plyBitstream, plyBitLength, plyDitTime, plyDahTime, plyDitGap} !== {expBs, expLen, expDit, expDah, expGap}) begin
            errors++;
            $display("[TB] FAIL reset_resnap: got %h expected %h", {plyBitLength, plyDitTime, plyDahTime, plyDitGap}, {expLen, expDit, expDah, expGap});
        end
        reqVec = '0;
        rstN   = 1'b0;
        #2;
        rstN   = 1'b1;
    endtask

    task automatic test_random();
        int m;
        int mode;
        repeat (12) begin
            reqVec = reqVec | 3'($urandom());
            if (reqVec == 3'b000) reqVec = 3'($urandom_range(1, 7));
            randomizeFields();
            m = $urandom_range(0, 5);
            mode = (m == 4) ? 1 : ((m == 5) ? 2 : 0);
            playOne($urandom_range(0, 60), mode, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
        end
        reqVec = '0;
    endtask

    initial begin
        rstN    = 1'b0;
        reqVec  = '0;
        plyBusy = 1'b0;
        plyDone = 1'b0;
        piezoIn = 1'b0;
        randomizeFields();
        test_reset();
        test_single();
        test_contention();
        test_snapshot();
        test_watchdog();
        test_back_to_back();
        test_priority_raise();
        test_reset_mid_play();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
